stack_seq: RTL

- Sequences the stack-pointer controls (push, pull) of the register file, and the matching stack-page memory cycles, for multi-byte stack operations: PHx/PLx, JSR, RTS, RTI, BRK/IRQ.
- Sits between the main CPU state machine, which issues one start per operation, and the register file plus the memory bus.
- Generates {8'h01,S} addresses, write data and write strobes, and collects pulled bytes into PC/P result registers.

---
 rtl/stack_seq_if.sv | 32 +++
 rtl/stack_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stack_seq_if.sv
// Stack sequencer bus: CPU start/op handshake, register-file S controls and
// the stack-page memory cycle signals. master = CPU side, slave = sequencer.
interface stack_seq_if;
  logic        start;
  logic [2:0]  op;
  logic        rdy;
  logic [7:0]  S;
  logic [15:0] pc;
  logic [7:0]  p;
  logic [7:0]  din;
  logic [7:0]  db_in;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic        push;
  logic        pull;
  logic        busy;
  logic        done;
  logic [15:0] pc_out;
  logic [7:0]  p_out;
  logic        wrap;

  modport master (
    output start, op, rdy, S, pc, p, din, db_in,
    input  addr, dout, we, push, pull, busy, done, pc_out, p_out, wrap
  );

  modport slave (
    input  start, op, rdy, S, pc, p, din, db_in,
    output addr, dout, we, push, pull, busy, done, pc_out, p_out, wrap
  );
endinterface

// File: rtl/stack_seq.sv
// Stack sequencer: turns one start per multi-byte stack operation (PHx/PLx,
// JSR, RTS, RTI, BRK/IRQ) into stack-page memory cycles plus push/pull
// strobes to the register file, and collects pulled bytes into pc_out/p_out.
// Optional: define STACK_WRAP_CHECK_EN to build the sticky S-wrap flag.
module stack_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input logic        clk,
  input logic        rst_n,
  stack_seq_if.slave bus
);

  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StPshH = 4'd1;
  localparam logic [3:0] StPshL = 4'd2;
  localparam logic [3:0] StPshP = 4'd3;
  localparam logic [3:0] StPshD = 4'd4;
  localparam logic [3:0] StPulP = 4'd5;
  localparam logic [3:0] StPulL = 4'd6;
  localparam logic [3:0] StPulH = 4'd7;
  localparam logic [3:0] StPulD = 4'd8;
  localparam logic [3:0] StFin  = 4'd9;

  localparam logic [2:0] OpPush1 = 3'd0;
  localparam logic [2:0] OpPull1 = 3'd1;
  localparam logic [2:0] OpJsr   = 3'd2;
  localparam logic [2:0] OpRts   = 3'd3;
  localparam logic [2:0] OpRti   = 3'd4;
  localparam logic [2:0] OpInt   = 3'd5;

  logic [3:0]  state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] pc_q;
  logic [7:0]  p_q;
  logic [7:0]  din_q;
  logic [15:0] pc_out_q;
  logic [7:0]  p_out_q;

  logic       accept;
  logic       in_push;
  logic       in_pull;
  logic [7:0] s_inc;

  assign accept  = (state_q == StIdle) && bus.start;
  assign in_push = (state_q == StPshH) || (state_q == StPshL) ||
                   (state_q == StPshP) || (state_q == StPshD);
  assign in_pull = (state_q == StPulP) || (state_q == StPulL) ||
                   (state_q == StPulH) || (state_q == StPulD);
  assign s_inc   = bus.S + 8'd1;

  // Next-state: dispatch on op from IDLE, advance only when rdy, FIN never stalls
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            OpPush1: state_d = StPshD;
            OpPull1: state_d = StPulD;
            OpJsr:   state_d = StPshH;
            OpRts:   state_d = StPulL;
            OpRti:   state_d = StPulP;
            OpInt:   state_d = StPshH;
            default: state_d = StFin;
          endcase
        end
      end
      StPshH: if (bus.rdy) state_d = StPshL;
      StPshL: if (bus.rdy) state_d = (op_q == OpInt) ? StPshP : StFin;
      StPshP: if (bus.rdy) state_d = StFin;
      StPshD: if (bus.rdy) state_d = StFin;
      StPulP: if (bus.rdy) state_d = StPulL;
      StPulL: if (bus.rdy) state_d = StPulH;
      StPulH: if (bus.rdy) state_d = StFin;
      StPulD: if (bus.rdy) state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch operands at start so later input changes cannot disturb the operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 3'd0;
      pc_q  <= 16'h0000;
      p_q   <= 8'h00;
      din_q <= 8'h00;
    end else if (accept) begin
      op_q  <= bus.op;
      pc_q  <= bus.pc;
      p_q   <= bus.p;
      din_q <= bus.din;
    end
  end

  // Capture pulled bytes on the advancing edge of each pull state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out_q <= 16'h0000;
      p_out_q  <= 8'h00;
    end else if (accept) begin
      pc_out_q <= 16'h0000;
      p_out_q  <= 8'h00;
    end else if (bus.rdy) begin
      case (state_q)
        StPulP:  p_out_q         <= bus.db_in;
        StPulL:  pc_out_q[7:0]   <= bus.db_in;
        StPulH:  pc_out_q[15:8]  <= bus.db_in;
        StPulD:  p_out_q         <= bus.db_in;
        default: ;
      endcase
    end
  end

  // Bus outputs decoded from state; strobes gated by rdy, addr/dout hold in a stall
  always_comb begin
    bus.addr = 16'h0000;
    bus.dout = 8'h00;
    if (in_push) begin
      bus.addr = {STACK_PAGE, bus.S};
    end else if (in_pull) begin
      bus.addr = {STACK_PAGE, s_inc};
    end
    case (state_q)
      StPshH:  bus.dout = pc_q[15:8];
      StPshL:  bus.dout = pc_q[7:0];
      StPshP:  bus.dout = p_q;
      StPshD:  bus.dout = din_q;
      default: bus.dout = 8'h00;
    endcase
  end

  assign bus.we     = in_push && bus.rdy;
  assign bus.push   = in_push && bus.rdy;
  assign bus.pull   = in_pull && bus.rdy;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StFin);
  assign bus.pc_out = pc_out_q;
  assign bus.p_out  = p_out_q;

`ifdef STACK_WRAP_CHECK_EN
  logic wrap_q;

  // Sticky wrap: push strobe at S=00 or pull strobe at S=FF; cleared on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else if (accept) begin
      wrap_q <= 1'b0;
    end else if ((bus.push && (bus.S == 8'h00)) || (bus.pull && (bus.S == 8'hFF))) begin
      wrap_q <= 1'b1;
    end
  end

  assign bus.wrap = wrap_q;
`else
  assign bus.wrap = 1'b0;
`endif

endmodule
